stark_const_sched: RTL
======================

# stark_const_sched

Multi-cycle scheduler that shares a small pool of `Stark_constant_decoder` ports among all instructions of a decode group. It accepts one cache line plus per-slot constant requests (position/size, up to two constants per slot) and grants requests to the decoder ports in fixed priority order. It captures the returned 32-bit constants into per-slot result registers and presents the complete group downstream with a valid/ready handshake. It sits between the instruction-align stage and the per-slot `Stark_decode_const` consumers.

## Interface
- `NSLOT`, 4: instructions per decode group.
- `NPORT`, 2: number of shared constant-decoder ports.
- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: synchronous abort of the current group.
- `grp_valid` in 1: offered group valid.
- `grp_ready` out 1: block accepts group this cycle.
- `grp_cline` in 512: cache line containing the constants.
- `grp_need` in 2*NSLOT: bit 2i+k = slot i requests constant k (k=0 uses pos[3:0]/isz[1:0], k=1 uses pos[7:4]/isz[3:2]).
- `grp_pos` in 8*NSLOT: per-slot `fnConstPos` value.
- `grp_isz` in 4*NSLOT: per-slot `fnConstSize` value.
- `dec_cline` out 512: registered line driven to all decoder ports.
- `dec_pos` out 4*NPORT: per-port position.
- `dec_isz` out 2*NPORT: per-port size.
- `dec_cnst` in 32*NPORT: combinational decoder results, same cycle.
- `out_valid` out 1: result group valid.
- `out_ready` in 1: downstream accepts result.
- `out_cnst` out 64*NSLOT: slot i constant k at bits [64i+32k +: 32]; unrequested entries are 0.
- `busy` out 1: state ≠ IDLE.

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- **IDLE**
  - `grp_ready`=1.
  - On `grp_valid`, register the cline, pos, isz and the pending mask (= `grp_need`), and clear `out_cnst`.
  - Go to RUN if the mask ≠ 0, otherwise go to DONE.
- **RUN**
  - Pending bits are scanned from bit 0 upward (slot 0 k0, slot 0 k1, slot 1 k0, …).
  - The first NPORT set bits are assigned to ports 0..NPORT-1 in order.
  - `dec_pos`/`dec_isz` are driven from the registered fields of the granted slot/k. Unused ports drive pos=0, isz=0.
  - At the clock edge, each granted `dec_cnst` is written into its `out_cnst` entry and its pending bit is cleared.
  - Go to DONE when the next mask is 0.
- **DONE**
  - `out_valid`=1; `out_cnst` holds stable.
  - On `out_ready`, go to IDLE.
  - No new group is accepted in the same cycle; `grp_ready` is 0 in DONE.
- **flush**: from any state, go to IDLE next cycle, clear the pending mask and drop `out_valid`. Flush takes priority over every other event, including simultaneous `grp_valid` in IDLE (the group is not accepted) and `out_ready` in DONE.
- **`grp_valid` deasserted in IDLE**: no state change.

## Timing
- **Reset values**: state=IDLE, `grp_ready`=1, `out_valid`=0, `busy`=0, `out_cnst`=0, `dec_cline`=0, `dec_pos`=0, `dec_isz`=0, pending mask=0.
- **Latency**, accept edge to `out_valid` high: 1 + ceil(popcount(need)/NPORT) cycles when need ≠ 0, and 1 cycle when need=0.
  - With defaults the maximum is 8 requests → 4 RUN cycles.
- **Throughput**: one group per (latency + 1) cycles when `out_ready` is held high.
- Decoder ports are combinational. `dec_*` outputs come from registers plus the priority encoder only, so there is no path from `dec_cnst` to `dec_pos`.
- `out_cnst` changes only on RUN-cycle captures and on IDLE accept.

## Test plan
- **Reset**: hold `rst` 2 cycles with `grp_valid`=1 → `grp_ready`=1, `out_valid`=0, and no group is accepted until `rst` falls.
- **Full group**: `grp_need`=8'hFF, NPORT=2 → exactly 4 RUN cycles.
  - Port grants per cycle are (s0k0,s0k1), (s1k0,s1k1), (s2k0,s2k1), (s3k0,s3k1).
  - `out_valid` rises 5 cycles after accept.
  - Each `out_cnst` entry equals a reference `Stark_constant_decoder` model applied to `grp_cline`.
- **Sparse group**: `grp_need`=8'b0100_0001 → 1 RUN cycle granting s0k0 on port 0 and s3k0 on port 1; port 0 shows pos=`grp_pos[3:0]`, port 1 shows pos=`grp_pos[27:24]`; all other `out_cnst` entries are 0.
- **Odd count**: `grp_need`=8'b0000_0111 → cycle 1 grants s0k0 and s0k1; cycle 2 grants s1k0 with port 1 idle (pos=0, isz=0).
- **No constants**: `grp_need`=0 → DONE one cycle after accept with `out_cnst`=0. Holding `out_ready`=0 for 3 cycles keeps `out_valid` and data stable; asserting it returns the FSM to IDLE on the next edge.
- **Flush**: `flush` in the second RUN cycle of an 8'hFF group → IDLE next cycle with `out_valid` never asserted. A following group with need=8'h01 completes normally, with no stale data in `out_cnst`.

Source files
------------

// File: rtl/stark_const_sched.sv
// rtl/stark_const_sched.sv - shares NPORT constant-decoder ports across a decode group
// Grants pending constant requests in fixed priority and collects results per slot.
module stark_const_sched #(
  parameter int NSLOT = 4,
  parameter int NPORT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  grp_valid,
  output logic                  grp_ready,
  input  logic [511:0]          grp_cline,
  input  logic [2*NSLOT-1:0]    grp_need,
  input  logic [8*NSLOT-1:0]    grp_pos,
  input  logic [4*NSLOT-1:0]    grp_isz,
  output logic [511:0]          dec_cline,
  output logic [4*NPORT-1:0]    dec_pos,
  output logic [2*NPORT-1:0]    dec_isz,
  input  logic [32*NPORT-1:0]   dec_cnst,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [64*NSLOT-1:0]   out_cnst,
  output logic                  busy
);

  localparam int NREQ = 2 * NSLOT;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state;
  logic [8*NSLOT-1:0]    pos_r;
  logic [4*NSLOT-1:0]    isz_r;
  logic [NREQ-1:0]       pend;
  logic [NREQ-1:0]       pend_next;
  logic [64*NSLOT-1:0]   out_next;

  // Request b (= 2*slot + k) owns pos nibble b, isz pair b and result word b,
  // so the grant loop indexes all three fields with the same linear number.
  always_comb begin
    int rank;
    rank      = 0;
    pend_next = pend;
    out_next  = out_cnst;
    dec_pos   = '0;
    dec_isz   = '0;
    if (state == RUN) begin
      for (int b = 0; b < NREQ; b++) begin
        if (pend[b]) begin
          for (int p = 0; p < NPORT; p++) begin
            if (rank == p) begin
              dec_pos[4*p +: 4]   = pos_r[4*b +: 4];
              dec_isz[2*p +: 2]   = isz_r[2*b +: 2];
              out_next[32*b +: 32] = dec_cnst[32*p +: 32];
              pend_next[b]        = 1'b0;
            end
          end
          rank = rank + 1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      dec_cline <= '0;
      pos_r     <= '0;
      isz_r     <= '0;
      pend      <= '0;
      out_cnst  <= '0;
      out_valid <= 1'b0;
      grp_ready <= 1'b1;
      busy      <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      pend      <= '0;
      out_valid <= 1'b0;
      grp_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grp_valid) begin
            dec_cline <= grp_cline;
            pos_r     <= grp_pos;
            isz_r     <= grp_isz;
            pend      <= grp_need;
            out_cnst  <= '0;
            grp_ready <= 1'b0;
            busy      <= 1'b1;
            if (grp_need != '0) begin
              state <= RUN;
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
            end
          end
        end
        RUN: begin
          out_cnst <= out_next;
          pend     <= pend_next;
          if (pend_next == '0) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            grp_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          grp_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
